// File: rtl/fp32_to_int32_cvt_if.sv
// ---------------------------------------------------------------------------
// fp32_to_int32_cvt_if
// Handshake bundle for the binary32 -> int32/uint32 converter.
//   in_valid    : operand valid (producer -> converter)
//   in_ready    : converter can take an operand this cycle
//   in_data     : binary32 operand {sign, exp[7:0], frac[22:0]}
//   in_signed   : 1 = signed int32 result, 0 = unsigned uint32 result
//   out_valid   : result valid (converter -> consumer)
//   out_ready   : consumer takes the result this cycle
//   out_data    : integer result
//   out_invalid : NaN, overflow, or negative non-zero into unsigned
//   out_inexact : fractional bits were discarded
// The master modport is the producer/consumer side, the slave modport is the
// converter itself.
// ---------------------------------------------------------------------------
interface fp32_to_int32_cvt_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_invalid, out_inexact
    );
endinterface

// File: rtl/fp32_to_int32_cvt.sv
// ---------------------------------------------------------------------------
// fp32_to_int32_cvt
// Two-stage pipelined IEEE-754 binary32 to 32-bit integer converter with
// valid/ready on both sides and one result per cycle sustained.
//   clk : clock, everything on the rising edge
//   rst : synchronous active-high reset, flushes both stages
//   bus : fp32_to_int32_cvt_if.slave (operand in, integer result out)
// Parameters NAN_S_VAL / NAN_U_VAL give the result for NaN operands in the
// signed / unsigned modes.
// Build option: define FP32_TO_INT_RNE_EN for round-to-nearest-even;
// when undefined the converter truncates toward zero.
// ---------------------------------------------------------------------------
module fp32_to_int32_cvt #(
    parameter logic [31:0] NAN_S_VAL = 32'h7FFF_FFFF,
    parameter logic [31:0] NAN_U_VAL = 32'hFFFF_FFFF
) (
    input logic                clk,
    input logic                rst,
    fp32_to_int32_cvt_if.slave bus
);

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } opClass_t;

    logic        r_s1Valid;
    logic        r_s1Sign;
    logic        r_s1Signed;
    logic [7:0]  r_s1Exp;
    logic [23:0] r_s1Mant;
    opClass_t    r_s1Class;

    logic        r_s2Valid;
    logic [31:0] r_outData;
    logic        r_outInvalid;
    logic        r_outInexact;

    logic        w_s1Adv;
    logic        w_inReady;
    logic [7:0]  w_inExp;
    logic [22:0] w_inFrac;
    opClass_t    w_inClass;

    logic [63:0] w_base;
    logic [63:0] w_scaled;
    logic [7:0]  w_rsh;
    logic [7:0]  w_lsh;
    logic        w_bigExp;
    logic        w_tinyExp;
    logic        w_ovf;
    logic [31:0] w_mag;
    logic        w_guard;
    logic        w_sticky;
    logic [31:0] w_magRnd;
    logic        w_inexactRaw;
    logic [31:0] w_resData;
    logic        w_resInvalid;
    logic        w_resInexact;

    // Stage 2 advances whenever it is empty or its result is being taken;
    // stage 1 can accept a new operand when it is empty or about to move on.
    assign w_s1Adv   = !r_s2Valid || bus.out_ready;
    assign w_inReady = !rst && (!r_s1Valid || w_s1Adv);

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = r_s2Valid;
    assign bus.out_data    = r_outData;
    assign bus.out_invalid = r_outInvalid;
    assign bus.out_inexact = r_outInexact;

    // Unpack the incoming operand and sort it into one of four classes.
    // A zero exponent covers both signed zeros and subnormals.
    assign w_inExp  = bus.in_data[30:23];
    assign w_inFrac = bus.in_data[22:0];

    always_comb begin
        w_inClass = CLS_NORMAL;
        if (w_inExp == 8'd0) begin
            w_inClass = CLS_ZERO;
        end else if (w_inExp == 8'hFF) begin
            w_inClass = (w_inFrac != 23'd0) ? CLS_NAN : CLS_INF;
        end
    end

    // Stage 1 register: holds the unpacked operand until stage 2 can take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Signed <= 1'b0;
            r_s1Exp    <= 8'd0;
            r_s1Mant   <= 24'd0;
            r_s1Class  <= CLS_ZERO;
        end else if (w_inReady) begin
            r_s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1Sign   <= bus.in_data[31];
                r_s1Signed <= bus.in_signed;
                r_s1Exp    <= w_inExp;
                r_s1Mant   <= {(w_inExp != 8'd0), w_inFrac};
                r_s1Class  <= w_inClass;
            end
        end
    end

    // Denormalize into a 32.32 fixed-point word. The mantissa is placed as an
    // integer in the upper half and shifted by the unbiased exponent
    // (E-150 relative to the mantissa LSB). Exponents 126..158 land fully
    // inside the window without losing bits; anything smaller than 126 is
    // below one half (guard clear, sticky set), anything from 159 up is at
    // least 2^32 and is handled purely as overflow.
    assign w_base    = {8'd0, r_s1Mant, 32'd0};
    assign w_rsh     = 8'd150 - r_s1Exp;
    assign w_lsh     = r_s1Exp - 8'd150;
    assign w_scaled  = (r_s1Exp <= 8'd150) ? (w_base >> w_rsh) : (w_base << w_lsh);
    assign w_bigExp  = (r_s1Exp >= 8'd159);
    assign w_tinyExp = (r_s1Exp <= 8'd125);
    assign w_ovf     = (r_s1Class == CLS_INF) || w_bigExp;

    assign w_mag        = w_tinyExp ? 32'd0 : w_scaled[63:32];
    assign w_guard      = w_tinyExp ? 1'b0  : w_scaled[31];
    assign w_sticky     = w_tinyExp ? 1'b1  : (w_scaled[30:0] != 31'd0);
    assign w_inexactRaw = w_guard || w_sticky;

`ifdef FP32_TO_INT_RNE_EN
    // Round to nearest, ties to even. A guard bit can only be set when the
    // magnitude is below 2^24, so the increment never carries out.
    logic w_roundUp;
    assign w_roundUp = w_guard && (w_sticky || w_mag[0]);
    assign w_magRnd  = w_mag + {31'd0, w_roundUp};
`else
    // Truncate toward zero: the discarded fraction only feeds the inexact flag.
    assign w_magRnd = w_mag;
`endif

    // Saturate, apply the sign and build the flags. The unsigned path checks
    // the sign first so that a negative overflow (including -inf) clamps to
    // zero rather than to all-ones.
    always_comb begin
        w_resData    = 32'd0;
        w_resInvalid = 1'b0;
        w_resInexact = 1'b0;
        case (r_s1Class)
            CLS_ZERO: begin
                w_resInexact = (r_s1Mant != 24'd0);
            end
            CLS_NAN: begin
                w_resData    = r_s1Signed ? NAN_S_VAL : NAN_U_VAL;
                w_resInvalid = 1'b1;
            end
            default: begin
                if (r_s1Signed) begin
                    if (!r_s1Sign && (w_ovf || w_magRnd > 32'h7FFF_FFFF)) begin
                        w_resData    = 32'h7FFF_FFFF;
                        w_resInvalid = 1'b1;
                    end else if (r_s1Sign && (w_ovf || w_magRnd > 32'h8000_0000)) begin
                        w_resData    = 32'h8000_0000;
                        w_resInvalid = 1'b1;
                    end else begin
                        w_resData    = r_s1Sign ? (-w_magRnd) : w_magRnd;
                        w_resInexact = w_inexactRaw;
                    end
                end else begin
                    if (r_s1Sign && (w_ovf || w_magRnd != 32'd0)) begin
                        w_resData    = 32'd0;
                        w_resInvalid = 1'b1;
                    end else if (w_ovf) begin
                        w_resData    = 32'hFFFF_FFFF;
                        w_resInvalid = 1'b1;
                    end else begin
                        w_resData    = w_magRnd;
                        w_resInexact = w_inexactRaw;
                    end
                end
            end
        endcase
    end

    // Stage 2 register: only loads when the previous result has been taken,
    // so a stalled result stays stable on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid    <= 1'b0;
            r_outData    <= 32'd0;
            r_outInvalid <= 1'b0;
            r_outInexact <= 1'b0;
        end else if (w_s1Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outData    <= w_resData;
                r_outInvalid <= w_resInvalid;
                r_outInexact <= w_resInexact;
            end
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_cvt.sv
// ---------------------------------------------------------------------------
// tb_fp32_to_int32_cvt
// Self-checking bench for fp32_to_int32_cvt: directed literal cases, a stall
// scenario, a mid-stream reset and a randomized run, all scored against a
// value-level reference model of the conversion.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp32_to_int32_cvt;

    logic clk = 1'b0;
    logic rst;

    fp32_to_int32_cvt_if bus ();

    fp32_to_int32_cvt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        invalid;
        logic        inexact;
    } result_t;

    result_t     expQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    logic        stallValid = 1'b0;
    logic [34:0] stallHold  = '0;

    // Reference model: the operand is expanded to an exact big fixed-point
    // value (150 fractional bits), split into integer and fraction, rounded
    // by comparing the fraction with one half, then clamped as a signed
    // 64-bit number against the int32/uint32 ranges.
    function automatic result_t refModel(input logic [31:0] f, input logic signedMode);
        result_t      r;
        int unsigned  ex;
        logic [191:0] big;
        logic [191:0] fracPart;
        logic [191:0] half;
        longint       intPart;
        longint       val;
        r        = '0;
        ex       = f[30:23];
        fracPart = '0;
        if (ex == 255 && f[22:0] != 23'd0) begin
            r.data    = signedMode ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            r.invalid = 1'b1;
            return r;
        end
        if (ex >= 159) begin
            intPart = 64'sd1 <<< 40;
        end else begin
            big      = {168'd0, (ex != 0), f[22:0]} << ((ex == 0) ? 1 : ex);
            intPart  = longint'(big[191:150]);
            fracPart = {42'd0, big[149:0]};
            half     = 192'd1 << 149;
`ifdef FP32_TO_INT_RNE_EN
            if (fracPart > half || (fracPart == half && intPart[0])) intPart = intPart + 1;
`endif
        end
        val = f[31] ? -intPart : intPart;
        if (signedMode) begin
            if (val > 64'sh7FFF_FFFF) begin
                r.data = 32'h7FFF_FFFF; r.invalid = 1'b1;
            end else if (val < -64'sh8000_0000) begin
                r.data = 32'h8000_0000; r.invalid = 1'b1;
            end else begin
                r.data = val[31:0]; r.inexact = (fracPart != 192'd0);
            end
        end else begin
            if (val < 0) begin
                r.data = 32'd0; r.invalid = 1'b1;
            end else if (val > 64'shFFFF_FFFF) begin
                r.data = 32'hFFFF_FFFF; r.invalid = 1'b1;
            end else begin
                r.data = val[31:0]; r.inexact = (fracPart != 192'd0);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checkCount++;
        if (act !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Drive one operand (caller sits just after a rising edge) and hold it
    // until the converter accepts it, with a bounded wait.
    task automatic applyStimulus(input logic [31:0] d, input logic s);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) checkOutput("acceptTimeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Directed case: pin the model to a hand-computed literal, then send the
    // operand through the DUT and compare against the same literal.
    task automatic runDirected(input string name, input logic [31:0] d, input logic s,
                               input logic [31:0] expData, input logic expInv, input logic expInex);
        result_t r;
        int      n;
        r = refModel(d, s);
        checkOutput({name, "_model"}, {30'd0, r.data, r.invalid, r.inexact},
                    {30'd0, expData, expInv, expInex});
        bus.out_ready = 1'b1;
        applyStimulus(d, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        checkOutput({name, "_latency"}, 64'(n), 64'd2);
        checkOutput({name, "_dut"}, {30'd0, bus.out_data, bus.out_invalid, bus.out_inexact},
                    {30'd0, expData, expInv, expInex});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randFloat();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5)       v[30:23] = 8'($urandom_range(100, 165));
        else if (k == 5) v[30:23] = 8'hFF;
        else if (k == 6) v[30:23] = 8'h00;
        else if (k == 7) v[22:0]  = 23'($urandom_range(0, 3)) << 20;
        return v;
    endfunction

    // Compare process: on every falling edge, record accepted operands in
    // the expectation queue, score every result that is taken, and require
    // a stalled result to stay unchanged on the next cycle.
    always @(negedge clk) begin
        result_t e;
        if (rst) begin
            expQ.delete();
            stallValid <= 1'b0;
        end else begin
            if (stallValid) begin
                checkOutput("stallStable", 64'({bus.out_valid, bus.out_data, bus.out_invalid, bus.out_inexact}),
                            64'(stallHold));
            end
            if (bus.in_valid && bus.in_ready) expQ.push_back(refModel(bus.in_data, bus.in_signed));
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedOut", 64'(bus.out_data), 64'hDEAD_0000_0000);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outData", 64'(bus.out_data), 64'(e.data));
                    checkOutput("outFlags", {62'd0, bus.out_invalid, bus.out_inexact},
                                {62'd0, e.invalid, e.inexact});
                end
            end
            stallValid <= bus.out_valid && !bus.out_ready;
            stallHold  <= {bus.out_valid, bus.out_data, bus.out_invalid, bus.out_inexact};
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed literals, stall, mid-stream reset,
    // randomized traffic, drain, summary.
    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetState", {29'd0, bus.out_valid, bus.in_ready, bus.out_invalid, bus.out_inexact, bus.out_data},
                    64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef FP32_TO_INT_RNE_EN
        runDirected("onePointFive", 32'h3FC0_0000, 1'b1, 32'd2, 1'b0, 1'b1);
        runDirected("threePointFive", 32'h4060_0000, 1'b1, 32'd4, 1'b0, 1'b1);
`else
        runDirected("onePointFive", 32'h3FC0_0000, 1'b1, 32'd1, 1'b0, 1'b1);
        runDirected("threePointFive", 32'h4060_0000, 1'b1, 32'd3, 1'b0, 1'b1);
`endif
        runDirected("twoPointFive", 32'h4020_0000, 1'b1, 32'd2, 1'b0, 1'b1);
        runDirected("pow31Signed", 32'h4F00_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        runDirected("pow31Unsigned", 32'h4F00_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        runDirected("negPow31Signed", 32'hCF00_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        runDirected("negOneUnsigned", 32'hBF80_0000, 1'b0, 32'd0, 1'b1, 1'b0);
        runDirected("nanSigned", 32'h7FC0_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        runDirected("nanUnsigned", 32'hFFC0_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runDirected("negInfSigned", 32'hFF80_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
        runDirected("negZeroUnsigned", 32'h8000_0000, 1'b0, 32'd0, 1'b0, 1'b0);
        runDirected("subnormal", 32'h0000_0001, 1'b1, 32'd0, 1'b0, 1'b1);
        runDirected("negHalfUnsigned", 32'hBF00_0000, 1'b0, 32'd0, 1'b0, 1'b1);
        runDirected("pow32Unsigned", 32'h4F80_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runDirected("minus100Signed", 32'hC2C8_0000, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0);

        // Stall: fill both stages with the consumer blocked, hold for three
        // cycles, then release and let all four results drain in order.
        bus.out_ready = 1'b0;
        applyStimulus(32'h3F80_0000, 1'b1);
        applyStimulus(32'h4000_0000, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h4040_0000;
        bus.in_signed = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stallInReady", {62'd0, bus.in_ready, bus.out_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(32'h4040_0000, 1'b1);
        applyStimulus(32'h4080_0000, 1'b1);
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stallDrain", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a stream: nothing survives the flush.
        bus.in_valid = 1'b1;
        repeat (4) begin
            bus.in_data   = randFloat();
            bus.in_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstInReady", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstFlush", {31'd0, bus.out_valid, bus.out_data}, 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = randFloat();
            bus.in_signed = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("finalDrain", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
